// File: rtl/nes_tetris_soc_spi_pkg.sv
// Register map and status/control bit positions for the SoC SPI link.
// Both ends of the link (master and slave) use these definitions.
package nes_tetris_soc_spi_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    typedef enum logic [ADDR_W-1:0] {
        REG_RXDATA  = 3'd0,
        REG_TXDATA  = 3'd1,
        REG_STATUS  = 3'd2,
        REG_CONTROL = 3'd3
    } spi_reg_e;

    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;
    localparam int ST_TMT  = 5;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;
    localparam int ST_E    = 8;
    localparam int ST_TUR  = 9;

    // Implemented interrupt-enable bits: iROE, iTOE, iTRDY, iRRDY, iE
    localparam logic [DATA_W-1:0] CTRL_MASK = 16'h01D8;

    function automatic logic [DATA_W-1:0] pack_status(
        input logic roe,
        input logic toe,
        input logic tmt,
        input logic trdy,
        input logic rrdy,
        input logic tur
    );
        logic [DATA_W-1:0] s;
        s          = '0;
        s[ST_ROE]  = roe;
        s[ST_TOE]  = toe;
        s[ST_TMT]  = tmt;
        s[ST_TRDY] = trdy;
        s[ST_RRDY] = rrdy;
        s[ST_E]    = roe | toe | tur;
        s[ST_TUR]  = tur;
        return s;
    endfunction

endpackage

// File: rtl/nes_tetris_soc_spi_slave_0_if.sv
// CPU register port of the SPI slave: select, address, read/write strobes,
// write data in, registered read data and interrupt out.
interface nes_tetris_soc_spi_slave_0_if;
    import nes_tetris_soc_spi_pkg::*;

    logic              spi_select;
    logic [ADDR_W-1:0] mem_addr;
    logic              read_n;
    logic              write_n;
    logic [DATA_W-1:0] data_from_cpu;
    logic [DATA_W-1:0] data_to_cpu;
    logic              irq;

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu, irq
    );

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu, irq
    );

endinterface

// File: rtl/nes_tetris_soc_spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// taken from the synchronized level (one extra flop of latency for edges).
module nes_tetris_soc_spi_sync #(
    parameter int   STAGES = 2,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_reg <= {STAGES{IDLE}};
            prev_reg  <= IDLE;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], async_in};
            prev_reg  <= chain_reg[STAGES-1];
        end
    end

    assign level = chain_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/nes_tetris_soc_spi_slave_0.sv
// Mode 0, MSB-first SPI slave with oversampled pins and a CPU register port
// (rx data, tx data, status, control) that raises irq on enabled events.
module nes_tetris_soc_spi_slave_0
    import nes_tetris_soc_spi_pkg::*;
#(
    parameter int                  DATABITS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [DATABITS-1:0] FILL_VALUE  = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    nes_tetris_soc_spi_slave_0_if.slave bus,
    input  logic                        SCLK,
    input  logic                        SS_n,
    input  logic                        MOSI,
    output logic                        MISO,
    output logic                        MISO_oe
);

    localparam int CNT_W = (DATABITS > 1) ? $clog2(DATABITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATABITS - 1);

    // Index 0 = SCLK, 1 = SS_n, 2 = MOSI; idle values match a quiet bus
    localparam logic [2:0] SYNC_IDLE = 3'b010;

    logic [2:0] pin_async;
    logic [2:0] sync_level;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    assign pin_async = {MOSI, SS_n, SCLK};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            nes_tetris_soc_spi_sync #(
                .STAGES (SYNC_STAGES),
                .IDLE   (SYNC_IDLE[gi])
            ) u_sync (
                .clk      (clk),
                .reset_n  (reset_n),
                .async_in (pin_async[gi]),
                .level    (sync_level[gi]),
                .rise     (sync_rise[gi]),
                .fall     (sync_fall[gi])
            );
        end
    endgenerate

    logic ss_low, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
    assign ss_low    = ~sync_level[1];
    assign ss_fall   = sync_fall[1];
    assign ss_rise   = sync_rise[1];
    assign sclk_rise = sync_rise[0] & ss_low;
    assign sclk_fall = sync_fall[0] & ss_low;
    assign mosi_s    = sync_level[2];

    // State
    logic [DATABITS-1:0] tx_hold_reg, tx_hold_next;
    logic                tx_primed_reg, tx_primed_next;
    logic [DATABITS-1:0] tx_sh_reg, tx_sh_next;
    logic [DATABITS-1:0] rx_sh_reg, rx_sh_next;
    logic [DATABITS-1:0] rx_hold_reg, rx_hold_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic                active_reg, active_next;
    logic                byte_done_reg, byte_done_next;
    logic                roe_reg, roe_next;
    logic                toe_reg, toe_next;
    logic                tur_reg, tur_next;
    logic                rrdy_reg, rrdy_next;
    logic [DATA_W-1:0]   ctrl_reg, ctrl_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                irq_reg, irq_next;
    logic                rd_access_reg, wr_access_reg;

    logic rd_access, wr_access, rd_stb, wr_stb;
    logic tx_wr, st_wr, ctl_wr, rx_rd;
    logic load, byte_complete;
    logic [DATA_W-1:0] status_word;

    assign rd_access = bus.spi_select & ~bus.read_n;
    assign wr_access = bus.spi_select & ~bus.write_n;
    assign rd_stb    = rd_access & ~rd_access_reg;
    assign wr_stb    = wr_access & ~wr_access_reg;

    assign rx_rd  = rd_stb & (bus.mem_addr == REG_RXDATA);
    assign tx_wr  = wr_stb & (bus.mem_addr == REG_TXDATA);
    assign st_wr  = wr_stb & (bus.mem_addr == REG_STATUS);
    assign ctl_wr = wr_stb & (bus.mem_addr == REG_CONTROL);

    // Reload happens on SS falling and on the falling edge that follows the last bit
    assign load          = ss_fall | (sclk_fall & active_reg & byte_done_reg);
    assign byte_complete = sclk_rise & active_reg & ~load & (bit_cnt_reg == LAST_BIT);

    assign status_word = pack_status(roe_reg, toe_reg, ~tx_primed_reg & ~active_reg,
                                     ~tx_primed_reg, rrdy_reg, tur_reg);

    always_comb begin
        tx_hold_next   = tx_hold_reg;
        tx_primed_next = tx_primed_reg;
        tx_sh_next     = tx_sh_reg;
        rx_sh_next     = rx_sh_reg;
        rx_hold_next   = rx_hold_reg;
        bit_cnt_next   = bit_cnt_reg;
        active_next    = active_reg;
        byte_done_next = byte_done_reg;
        roe_next       = roe_reg;
        toe_next       = toe_reg;
        tur_next       = tur_reg;
        rrdy_next      = rrdy_reg;
        ctrl_next      = ctrl_reg;
        rdata_next     = rdata_reg;
        irq_next       = |(status_word & ctrl_reg);

        if (rd_stb) begin
            case (bus.mem_addr)
                REG_RXDATA:  rdata_next = DATA_W'(rx_hold_reg);
                REG_STATUS:  rdata_next = status_word;
                REG_CONTROL: rdata_next = ctrl_reg;
                default:     rdata_next = '0;
            endcase
        end

        // Clears first so that same-cycle sets below win
        if (st_wr) begin
            roe_next  = 1'b0;
            toe_next  = 1'b0;
            tur_next  = 1'b0;
            rrdy_next = 1'b0;
        end
        if (rx_rd) begin
            rrdy_next = 1'b0;
        end
        if (ctl_wr) begin
            ctrl_next = bus.data_from_cpu & CTRL_MASK;
        end

        if (load) begin
            tx_sh_next     = tx_primed_reg ? tx_hold_reg : FILL_VALUE;
            tx_primed_next = 1'b0;
            if (!tx_primed_reg) begin
                tur_next = 1'b1;
            end
            bit_cnt_next   = '0;
            active_next    = 1'b1;
            byte_done_next = 1'b0;
            rx_sh_next     = '0;
        end else if (sclk_fall && active_reg) begin
            tx_sh_next = {tx_sh_reg[DATABITS-2:0], 1'b0};
        end

        if (sclk_rise && active_reg && !load) begin
            rx_sh_next = {rx_sh_reg[DATABITS-2:0], mosi_s};
            if (byte_complete) begin
                rx_hold_next   = {rx_sh_reg[DATABITS-2:0], mosi_s};
                rrdy_next      = 1'b1;
                byte_done_next = 1'b1;
                bit_cnt_next   = '0;
                if (rrdy_reg) begin
                    roe_next = 1'b1;
                end
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end

        // A write landing with a load primes the hold after the load consumed it
        if (tx_wr) begin
            if (!tx_primed_reg || load) begin
                tx_hold_next   = bus.data_from_cpu[DATABITS-1:0];
                tx_primed_next = 1'b1;
            end else begin
                toe_next = 1'b1;
            end
        end

        if (ss_rise) begin
            active_next    = 1'b0;
            bit_cnt_next   = '0;
            byte_done_next = 1'b0;
            rx_sh_next     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold_reg   <= '0;
            tx_primed_reg <= 1'b0;
            tx_sh_reg     <= '0;
            rx_sh_reg     <= '0;
            rx_hold_reg   <= '0;
            bit_cnt_reg   <= '0;
            active_reg    <= 1'b0;
            byte_done_reg <= 1'b0;
            roe_reg       <= 1'b0;
            toe_reg       <= 1'b0;
            tur_reg       <= 1'b0;
            rrdy_reg      <= 1'b0;
            ctrl_reg      <= '0;
            rdata_reg     <= '0;
            irq_reg       <= 1'b0;
            rd_access_reg <= 1'b0;
            wr_access_reg <= 1'b0;
        end else begin
            tx_hold_reg   <= tx_hold_next;
            tx_primed_reg <= tx_primed_next;
            tx_sh_reg     <= tx_sh_next;
            rx_sh_reg     <= rx_sh_next;
            rx_hold_reg   <= rx_hold_next;
            bit_cnt_reg   <= bit_cnt_next;
            active_reg    <= active_next;
            byte_done_reg <= byte_done_next;
            roe_reg       <= roe_next;
            toe_reg       <= toe_next;
            tur_reg       <= tur_next;
            rrdy_reg      <= rrdy_next;
            ctrl_reg      <= ctrl_next;
            rdata_reg     <= rdata_next;
            irq_reg       <= irq_next;
            rd_access_reg <= rd_access;
            wr_access_reg <= wr_access;
        end
    end

    assign bus.data_to_cpu = rdata_reg;
    assign bus.irq         = irq_reg;
    assign MISO            = tx_sh_reg[DATABITS-1];
    assign MISO_oe         = ss_low;

endmodule

// File: tb/tb_nes_tetris_soc_spi_slave_0.sv
// Directed bench for the SPI slave: a bus-functional SPI master and CPU port,
// expected values queued at stimulus time and popped when observed.
module tb_nes_tetris_soc_spi_slave_0;
    import nes_tetris_soc_spi_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic SCLK = 1'b0;
    logic SS_n = 1'b1;
    logic MOSI = 1'b0;
    logic MISO, MISO_oe;

    nes_tetris_soc_spi_slave_0_if cpu ();

    nes_tetris_soc_spi_slave_0 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (cpu),
        .SCLK    (SCLK),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_oe (MISO_oe)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    task automatic push_exp(input string tag, input logic [15:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop(input logic [15:0] obs);
        string       tag;
        logic [15:0] expv;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            expv = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (obs === expv) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
            end
            $display("check %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu.spi_select = 1'b1; cpu.mem_addr = a; cpu.data_from_cpu = d; cpu.write_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cpu.spi_select = 1'b0; cpu.write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        cpu.spi_select = 1'b1; cpu.mem_addr = a; cpu.read_n = 1'b0;
        @(negedge clk);
        d = cpu.data_to_cpu;
        @(negedge clk);
        cpu.spi_select = 1'b0; cpu.read_n = 1'b1;
        clk_wait(2);
    endtask

    task automatic frame_start();
        SS_n = 1'b0;
        clk_wait(6);
    endtask

    task automatic frame_end();
        clk_wait(10);
        SS_n = 1'b1;
        clk_wait(8);
    endtask

    // One SCLK bit at clk/20: MISO sampled just before the rising edge
    task automatic spi_bit(input logic mo, output logic mi);
        MOSI = mo;
        clk_wait(10);
        mi = MISO;
        SCLK = 1'b1;
        clk_wait(10);
        SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], mi[i]);
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  mi;
        logic        b;

        cpu.spi_select = 1'b0; cpu.mem_addr = '0; cpu.read_n = 1'b1;
        cpu.write_n = 1'b1; cpu.data_from_cpu = '0;

        // Reset state
        push_exp("rst_data", 16'h0000); push_exp("rst_irq", 16'h0);
        push_exp("rst_miso", 16'h0);    push_exp("rst_oe", 16'h0);
        clk_wait(4);
        check_pop(cpu.data_to_cpu); check_pop({15'b0, cpu.irq});
        check_pop({15'b0, MISO});   check_pop({15'b0, MISO_oe});
        reset_n = 1'b1;
        clk_wait(4);
        push_exp("idle_status", 16'h0060);
        cpu_read(REG_STATUS, rd); check_pop(rd);

        // Basic exchange: slave sends 0xA5, master sends 0x3C
        cpu_write(REG_TXDATA, 16'h00A5);
        push_exp("primed_status", 16'h0000);
        cpu_read(REG_STATUS, rd); check_pop(rd);
        push_exp("oe_in_frame", 16'h1);
        push_exp("miso_a5", 16'h00A5);
        frame_start();
        check_pop({15'b0, MISO_oe});
        spi_byte(8'h3C, mi);
        frame_end();
        check_pop({8'h0, mi});
        push_exp("status_after_3c", 16'h03E0);
        cpu_read(REG_STATUS, rd); check_pop(rd);
        push_exp("rx_3c", 16'h003C);
        cpu_read(REG_RXDATA, rd); check_pop(rd);
        push_exp("rrdy_cleared", 16'h0360);
        cpu_read(REG_STATUS, rd); check_pop(rd);
        cpu_write(REG_STATUS, 16'h0000);

        // Two bytes under one SS, no tx data, no read between: ROE, TUR, fill
        cpu_write(REG_CONTROL, 16'h0008);
        push_exp("fill_byte1", 16'h0000);
        push_exp("fill_byte2", 16'h0000);
        frame_start();
        spi_byte(8'h11, mi); check_pop({8'h0, mi});
        spi_byte(8'h22, mi); check_pop({8'h0, mi});
        frame_end();
        push_exp("overrun_status", 16'h03E8);
        push_exp("irq_roe", 16'h1);
        cpu_read(REG_STATUS, rd); check_pop(rd);
        check_pop({15'b0, cpu.irq});
        push_exp("rx_second", 16'h0022);
        cpu_read(REG_RXDATA, rd); check_pop(rd);
        cpu_write(REG_STATUS, 16'hFFFF);
        push_exp("status_cleared", 16'h0060);
        push_exp("irq_cleared", 16'h0);
        cpu_read(REG_STATUS, rd); check_pop(rd);
        check_pop({15'b0, cpu.irq});

        // Double tx write: TOE, first value kept
        cpu_write(REG_CONTROL, 16'h0000);
        cpu_write(REG_TXDATA, 16'h005A);
        cpu_write(REG_TXDATA, 16'h0099);
        push_exp("toe_status", 16'h0110);
        cpu_read(REG_STATUS, rd); check_pop(rd);
        push_exp("miso_5a", 16'h005A);
        frame_start();
        spi_byte(8'h00, mi);
        frame_end();
        check_pop({8'h0, mi});
        cpu_read(REG_RXDATA, rd);
        cpu_write(REG_STATUS, 16'h0000);

        // Abort after 5 bits, then a full 0x81
        frame_start();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        frame_end();
        push_exp("oe_between", 16'h0);
        push_exp("abort_status", 16'h0360);
        check_pop({15'b0, MISO_oe});
        cpu_read(REG_STATUS, rd); check_pop(rd);
        cpu_write(REG_STATUS, 16'h0000);
        push_exp("miso_fill", 16'h0000);
        frame_start();
        spi_byte(8'h81, mi);
        frame_end();
        check_pop({8'h0, mi});
        push_exp("rx_81", 16'h0081);
        cpu_read(REG_RXDATA, rd); check_pop(rd);

        // Reset mid-byte with irq and MISO high beforehand
        cpu_write(REG_CONTROL, 16'h0100);
        cpu_write(REG_TXDATA, 16'h00C3);
        cpu_write(REG_TXDATA, 16'h0011);
        clk_wait(2);
        push_exp("irq_e_before_rst", 16'h1);
        check_pop({15'b0, cpu.irq});
        frame_start();
        spi_bit(1'b1, b);
        clk_wait(6);
        push_exp("miso_mid_byte", 16'h1);
        check_pop({15'b0, MISO});
        reset_n = 1'b0;
        clk_wait(2);
        push_exp("mrst_data", 16'h0000); push_exp("mrst_irq", 16'h0);
        push_exp("mrst_miso", 16'h0);    push_exp("mrst_oe", 16'h0);
        check_pop(cpu.data_to_cpu); check_pop({15'b0, cpu.irq});
        check_pop({15'b0, MISO});   check_pop({15'b0, MISO_oe});
        SS_n = 1'b1;
        clk_wait(3);
        reset_n = 1'b1;
        clk_wait(5);
        push_exp("post_rst_status", 16'h0060);
        cpu_read(REG_STATUS, rd); check_pop(rd);
        cpu_write(REG_TXDATA, 16'h003C);
        push_exp("miso_post_rst", 16'h003C);
        frame_start();
        spi_byte(8'hE7, mi);
        frame_end();
        check_pop({8'h0, mi});
        push_exp("rx_e7", 16'h00E7);
        cpu_read(REG_RXDATA, rd); check_pop(rd);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
